// File: rtl/cnet_reprogram.sv
// SelectMAP master that reprograms the CNET FPGA from a stream of 32-bit bitstream words.
// rp_* pins and FSM state move only on rp_cclk falling edges so they are stable at every rising edge.
module cnet_reprogram #(
    parameter int CCLK_HALF     = 2,
    parameter int PROG_B_CYCLES = 16,
    parameter int INIT_TIMEOUT  = 1024,
    parameter int DONE_TIMEOUT  = 1024,
    parameter int WORD_CNT_W    = 21
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic [WORD_CNT_W-1:0] total_words,
    input  logic [31:0]           word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  busy,
    output logic                  prog_done,
    output logic                  prog_error,
    output logic [1:0]            error_code,
    output logic                  rp_cclk,
    output logic                  rp_prog_b,
    input  logic                  rp_init_b,
    output logic                  rp_cs_b,
    output logic                  rp_rdwr_b,
    output logic [7:0]            rp_data,
    input  logic                  rp_done
);

    localparam int TMAX_A = (INIT_TIMEOUT > DONE_TIMEOUT) ? INIT_TIMEOUT : DONE_TIMEOUT;
    localparam int TMAX   = (TMAX_A > PROG_B_CYCLES) ? TMAX_A : PROG_B_CYCLES;
    localparam int TICK_W = $clog2(TMAX + 1);
    localparam int DIV_W  = $clog2(CCLK_HALF + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROG_LOW  = 3'd1,
        ST_WAIT_INIT = 3'd2,
        ST_LOAD      = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    // SelectMAP expects D0 on the MSB pin
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    logic [DIV_W-1:0]      div_cnt_r;
    logic                  cclk_r;
    logic                  fall_tick_s;
    state_t                state_r, state_nxt_s, state_d_s;
    logic [TICK_W-1:0]     tick_cnt_r, tick_cnt_nxt_s;
    logic [31:0]           shift_r, shift_nxt_s;
    logic [1:0]            byte_idx_r, byte_idx_nxt_s;
    logic                  prog_b_r, prog_b_nxt_s;
    logic                  cs_b_r, cs_b_nxt_s;
    logic                  rdwr_b_r, rdwr_b_nxt_s;
    logic [7:0]            data_r, data_nxt_s;
    logic                  load_word_s, set_done_s, set_err_s;
    logic [1:0]            err_code_nxt_s;
    logic [31:0]           buf_r;
    logic                  buf_full_r, buf_full_d_s;
    logic                  accept_s, start_acc_s;
    logic                  word_ready_r, busy_r, prog_done_r, prog_error_r;
    logic [1:0]            error_code_r;
    logic [WORD_CNT_W-1:0] words_left_r;

    assign fall_tick_s = (div_cnt_r == DIV_W'(CCLK_HALF - 1)) && cclk_r;
    assign start_acc_s = start && !busy_r;
    assign accept_s    = word_valid && word_ready_r;
    assign state_d_s   = fall_tick_s ? state_nxt_s : state_r;

    // Free-running configuration clock divider
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            div_cnt_r <= DIV_W'(0);
            cclk_r    <= 1'b0;
        end else if (div_cnt_r == DIV_W'(CCLK_HALF - 1)) begin
            div_cnt_r <= DIV_W'(0);
            cclk_r    <= !cclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Next-state and pin values, applied only on fall-ticks
    always_comb begin
        state_nxt_s    = state_r;
        tick_cnt_nxt_s = tick_cnt_r;
        shift_nxt_s    = shift_r;
        byte_idx_nxt_s = byte_idx_r;
        prog_b_nxt_s   = prog_b_r;
        cs_b_nxt_s     = cs_b_r;
        rdwr_b_nxt_s   = rdwr_b_r;
        data_nxt_s     = data_r;
        load_word_s    = 1'b0;
        set_done_s     = 1'b0;
        set_err_s      = 1'b0;
        err_code_nxt_s = 2'd0;
        case (state_r)
            ST_IDLE: begin
                if (busy_r) begin
                    state_nxt_s    = ST_PROG_LOW;
                    prog_b_nxt_s   = 1'b0;
                    rdwr_b_nxt_s   = 1'b0;
                    tick_cnt_nxt_s = TICK_W'(0);
                end else begin
                    prog_b_nxt_s = 1'b1;
                    cs_b_nxt_s   = 1'b1;
                    rdwr_b_nxt_s = 1'b1;
                end
            end
            ST_PROG_LOW: begin
                if (tick_cnt_r == TICK_W'(PROG_B_CYCLES - 1)) begin
                    prog_b_nxt_s   = 1'b1;
                    tick_cnt_nxt_s = TICK_W'(0);
                    state_nxt_s    = ST_WAIT_INIT;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
                end
            end
            ST_WAIT_INIT: begin
                if (rp_init_b) begin
                    tick_cnt_nxt_s = TICK_W'(0);
                    state_nxt_s    = (words_left_r == WORD_CNT_W'(0)) ? ST_WAIT_DONE : ST_LOAD;
                end else if (tick_cnt_r == TICK_W'(INIT_TIMEOUT - 1)) begin
                    set_err_s      = 1'b1;
                    err_code_nxt_s = 2'd1;
                    state_nxt_s    = ST_ERROR;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
                end
            end
            ST_LOAD: begin
                cs_b_nxt_s = 1'b1;
                if (!rp_init_b) begin
                    set_err_s      = 1'b1;
                    err_code_nxt_s = 2'd2;
                    state_nxt_s    = ST_ERROR;
                end else if (buf_full_r) begin
                    load_word_s    = 1'b1;
                    shift_nxt_s    = buf_r;
                    data_nxt_s     = rev8(buf_r[7:0]);
                    byte_idx_nxt_s = 2'd0;
                    cs_b_nxt_s     = 1'b0;
                    state_nxt_s    = ST_SEND;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_SEND: begin
                if (!rp_init_b) begin
                    set_err_s      = 1'b1;
                    err_code_nxt_s = 2'd2;
                    cs_b_nxt_s     = 1'b1;
                    state_nxt_s    = ST_ERROR;
                end else if (byte_idx_r != 2'd3) begin
                    byte_idx_nxt_s = byte_idx_r + 2'd1;
                    shift_nxt_s    = {8'h00, shift_r[31:8]};
                    data_nxt_s     = rev8(shift_r[15:8]);
                end else if (words_left_r == WORD_CNT_W'(0)) begin
                    cs_b_nxt_s     = 1'b1;
                    tick_cnt_nxt_s = TICK_W'(0);
                    state_nxt_s    = ST_WAIT_DONE;
                end else if (buf_full_r) begin
                    // back-to-back word: chip select stays low
                    load_word_s    = 1'b1;
                    shift_nxt_s    = buf_r;
                    data_nxt_s     = rev8(buf_r[7:0]);
                    byte_idx_nxt_s = 2'd0;
                end else begin
                    cs_b_nxt_s  = 1'b1;
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_WAIT_DONE: begin
                cs_b_nxt_s = 1'b1;
                if (rp_done) begin
                    set_done_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (tick_cnt_r == TICK_W'(DONE_TIMEOUT - 1)) begin
                    set_err_s      = 1'b1;
                    err_code_nxt_s = 2'd3;
                    state_nxt_s    = ST_ERROR;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
                end
            end
            ST_DONE, ST_ERROR: begin
                cs_b_nxt_s   = 1'b1;
                prog_b_nxt_s = 1'b1;
                rdwr_b_nxt_s = 1'b1;
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Tick-domain state and programming pins
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= TICK_W'(0);
            shift_r    <= 32'h0000_0000;
            byte_idx_r <= 2'd0;
            prog_b_r   <= 1'b1;
            cs_b_r     <= 1'b1;
            rdwr_b_r   <= 1'b1;
            data_r     <= 8'h00;
        end else if (fall_tick_s) begin
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            byte_idx_r <= byte_idx_nxt_s;
            prog_b_r   <= prog_b_nxt_s;
            cs_b_r     <= cs_b_nxt_s;
            rdwr_b_r   <= rdwr_b_nxt_s;
            data_r     <= data_nxt_s;
        end
    end

    // Status flags and word counter; start acceptance wins over tick updates
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            busy_r       <= 1'b0;
            prog_done_r  <= 1'b0;
            prog_error_r <= 1'b0;
            error_code_r <= 2'd0;
            words_left_r <= WORD_CNT_W'(0);
        end else if (start_acc_s) begin
            busy_r       <= 1'b1;
            prog_done_r  <= 1'b0;
            prog_error_r <= 1'b0;
            error_code_r <= 2'd0;
            words_left_r <= total_words;
        end else if (fall_tick_s) begin
            if (set_done_s) begin
                prog_done_r <= 1'b1;
                busy_r      <= 1'b0;
            end
            if (set_err_s) begin
                prog_error_r <= 1'b1;
                error_code_r <= err_code_nxt_s;
                busy_r       <= 1'b0;
            end
            if (load_word_s && (words_left_r != WORD_CNT_W'(0))) begin
                words_left_r <= words_left_r - WORD_CNT_W'(1);
            end
        end
    end

    // Buffer occupancy; a new start discards any word left from an aborted load
    always_comb begin
        if (start_acc_s) begin
            buf_full_d_s = 1'b0;
        end else if (accept_s) begin
            buf_full_d_s = 1'b1;
        end else if (fall_tick_s && load_word_s) begin
            buf_full_d_s = 1'b0;
        end else begin
            buf_full_d_s = buf_full_r;
        end
    end

    // One-word input buffer and registered ready
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            buf_r        <= 32'h0000_0000;
            buf_full_r   <= 1'b0;
            word_ready_r <= 1'b0;
        end else begin
            buf_full_r   <= buf_full_d_s;
            word_ready_r <= !buf_full_d_s && ((state_d_s == ST_LOAD) || (state_d_s == ST_SEND));
            if (accept_s) begin
                buf_r <= word_data;
            end
        end
    end

    assign word_ready = word_ready_r;
    assign busy       = busy_r;
    assign prog_done  = prog_done_r;
    assign prog_error = prog_error_r;
    assign error_code = error_code_r;
    assign rp_cclk    = cclk_r;
    assign rp_prog_b  = prog_b_r;
    assign rp_cs_b    = cs_b_r;
    assign rp_rdwr_b  = rdwr_b_r;
    assign rp_data    = data_r;

endmodule

// File: tb/tb_cnet_reprogram.sv
// Bench for cnet_reprogram: CNET SelectMAP emulator plus a byte scoreboard filled as words are accepted.
module tb_cnet_reprogram;

    localparam int CCLK_HALF     = 2;
    localparam int PROG_B_CYCLES = 16;
    localparam int INIT_TIMEOUT  = 8;
    localparam int DONE_TIMEOUT  = 16;
    localparam int WORD_CNT_W    = 21;
    localparam int TICK_CLK      = 2 * CCLK_HALF;

    logic                  clk = 1'b0;
    logic                  reset_b = 1'b0;
    logic                  start = 1'b0;
    logic [WORD_CNT_W-1:0] total_words = '0;
    logic [31:0]           word_data = 32'h0;
    logic                  word_valid = 1'b0;
    logic                  word_ready, busy, prog_done, prog_error;
    logic [1:0]            error_code;
    logic                  rp_cclk, rp_prog_b, rp_init_b, rp_cs_b, rp_rdwr_b, rp_done;
    logic [7:0]            rp_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    // emulator controls and observations
    bit   init_en = 1'b1;
    bit   done_en = 1'b1;
    int   crc_at = 0;
    int   emu_want = 12;
    int   init_cnt = 0, rx_cnt = 0, cs_low_total = 0, cs_runs = 0;
    bit   crc_hit = 1'b0;
    logic cs_prev = 1'b1;
    logic emu_init = 1'b0;
    logic emu_done = 1'b0;

    assign rp_init_b = emu_init;
    assign rp_done   = emu_done;

    cnet_reprogram #(
        .CCLK_HALF(CCLK_HALF), .PROG_B_CYCLES(PROG_B_CYCLES), .INIT_TIMEOUT(INIT_TIMEOUT),
        .DONE_TIMEOUT(DONE_TIMEOUT), .WORD_CNT_W(WORD_CNT_W)
    ) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .total_words(total_words),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .prog_done(prog_done), .prog_error(prog_error), .error_code(error_code),
        .rp_cclk(rp_cclk), .rp_prog_b(rp_prog_b), .rp_init_b(rp_init_b), .rp_cs_b(rp_cs_b),
        .rp_rdwr_b(rp_rdwr_b), .rp_data(rp_data), .rp_done(rp_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] unrev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // CNET configuration port model, clocked by rp_cclk
    always @(posedge rp_cclk) begin
        if (!rp_prog_b) begin
            init_cnt = 0; rx_cnt = 0; crc_hit = 1'b0;
            cs_low_total = 0; cs_runs = 0; cs_prev = 1'b1;
            emu_init <= 1'b0;
            emu_done <= 1'b0;
        end else begin
            if (!rp_cs_b && !rp_rdwr_b) begin
                rx_q.push_back(unrev(rp_data));
                rx_cnt++;
                cs_low_total++;
                if (cs_prev) cs_runs++;
                if (crc_at != 0 && rx_cnt == crc_at) crc_hit = 1'b1;
            end
            cs_prev = rp_cs_b;
            if (init_cnt < 3) init_cnt++;
            emu_init <= init_en && (init_cnt >= 3) && !crc_hit;
            emu_done <= done_en && emu_init && (rx_cnt == emu_want);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        logic [17:0] obs, req;
        obs = {rp_cclk, rp_prog_b, rp_cs_b, rp_rdwr_b, rp_data, word_ready,
               busy, prog_done, prog_error, error_code};
        req = {1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        check(tag, {14'd0, obs}, {14'd0, req});
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        total_words = WORD_CNT_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // present one word; scoreboard gets its four bytes at the accepting edge
    task automatic send_word(input logic [31:0] w, input int gap, input string tag);
        bit ok = 1'b0;
        int n = 0;
        @(negedge clk);
        word_data = w;
        word_valid = 1'b1;
        while (!ok && n < 4000) begin
            if (word_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (ok) begin
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end else begin
            check({tag, "_accept_timeout"}, 32'(ok), 32'd1);
        end
        #1;
        word_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_cs(input logic lvl, input string tag);
        int n = 0;
        while (rp_cs_b !== lvl && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_cs_wait"}, 32'(rp_cs_b), 32'(lvl));
    endtask

    task automatic drain(input int n, input string tag);
        check({tag, "_byte_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() > 0 && exp_q.size() > 0)
                check($sformatf("%s_byte%0d", tag, i), 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] w;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_values");
        @(negedge clk);
        reset_b = 1'b1;

        // normal back-to-back load
        do_start(3);
        check("busy_after_start", 32'(busy), 32'd1);
        send_word(32'h0403_0201, 0, "n_w0");
        send_word(32'h0807_0605, 0, "n_w1");
        send_word(32'h0C0B_0A09, 0, "n_w2");
        wait_idle("normal");
        check("normal_done", 32'(prog_done), 32'd1);
        check("normal_code", {29'd0, prog_error, error_code}, 32'd0);
        check("normal_cs_low", 32'(cs_low_total), 32'd12);
        check("normal_cs_runs", 32'(cs_runs), 32'd1);
        drain(12, "normal");

        // stalled source: a chip-select gap after every word
        do_start(3);
        send_word(32'hA1B2_C3D4, 20, "s_w0");
        send_word(32'h5566_7788, 20, "s_w1");
        send_word(32'h0F1E_2D3C, 0, "s_w2");
        wait_idle("stall");
        check("stall_done", 32'(prog_done), 32'd1);
        check("stall_cs_runs", 32'(cs_runs), 32'd3);
        check("stall_cs_low", 32'(cs_low_total), 32'd12);
        drain(12, "stall");

        // CRC error: emulator drops init_b after the sixth byte
        crc_at = 6;
        do_start(3);
        send_word(32'h1111_2222, 0, "c_w0");
        send_word(32'h3333_4444, 0, "c_w1");
        send_word(32'h5555_6666, 0, "c_w2");
        wait_idle("crc");
        check("crc_flags", {28'd0, prog_done, prog_error, error_code}, 32'h6);
        check("crc_pins", {30'd0, rp_cs_b, rp_prog_b}, 32'h3);
        drain(6, "crc");
        crc_at = 0;

        // init timeout: measured from rp_prog_b release
        init_en = 1'b0;
        do_start(3);
        n = 0;
        while (rp_prog_b && n < 2000) begin @(posedge clk); #1; n++; end
        check("it_prog_low", 32'(rp_prog_b), 32'd0);
        n = 0;
        while (!rp_prog_b && n < 2000) begin @(posedge clk); #1; n++; end
        check("it_prog_high", 32'(rp_prog_b), 32'd1);
        n = 0;
        while (!prog_error && n < 2000) begin @(posedge clk); #1; n++; end
        check("it_latency_clk", 32'(n), 32'(INIT_TIMEOUT * TICK_CLK));
        check("it_code", {29'd0, busy, error_code}, 32'd1);
        check("it_no_cs", 32'(cs_low_total), 32'd0);
        init_en = 1'b1;
        exp_q.delete();
        rx_q.delete();

        // done timeout with a single word
        done_en = 1'b0;
        do_start(1);
        send_word(32'hDEAD_BEEF, 0, "d_w0");
        wait_cs(1'b0, "dt_low");
        wait_cs(1'b1, "dt_high");
        n = 0;
        while (!prog_error && n < 2000) begin @(posedge clk); #1; n++; end
        check("dt_latency_clk", 32'(n), 32'(DONE_TIMEOUT * TICK_CLK));
        check("dt_code", 32'(error_code), 32'd3);
        drain(4, "dt");
        done_en = 1'b1;

        // zero-length bitstream goes straight to waiting for done
        emu_want = 0;
        do_start(0);
        wait_idle("zero");
        check("zero_done", {30'd0, prog_done, prog_error}, 32'h2);
        check("zero_no_cs", 32'(cs_low_total), 32'd0);
        emu_want = 12;

        // start while busy must not reload the word count
        do_start(3);
        send_word(32'h1357_9BDF, 0, "b_w0");
        wait_cs(1'b0, "busy_send");
        do_start(5);
        send_word(32'h2468_ACE0, 0, "b_w1");
        send_word(32'hFEDC_BA98, 0, "b_w2");
        wait_idle("restart");
        check("restart_done", 32'(prog_done), 32'd1);
        drain(12, "restart");

        // reset in the middle of a send
        do_start(3);
        send_word(32'hCAFE_F00D, 0, "r_w0");
        wait_cs(1'b0, "rst_send");
        reset_b = 1'b0;
        #1;
        check_reset_state("reset_mid_send");
        repeat (4) @(posedge clk);
        #1;
        check_reset_state("reset_held");
        @(negedge clk);
        reset_b = 1'b1;
        exp_q.delete();
        rx_q.delete();

        // clean load after the abort
        do_start(3);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            send_word(w, 0, "clean_w");
        end
        wait_idle("clean");
        check("clean_done", {29'd0, prog_done, error_code}, 32'h4);
        check("clean_cs_runs", 32'(cs_runs), 32'd1);
        drain(12, "clean");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
